// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Predictive RV32I forwarding unit for a 5-stage F/D/X/M/W pipeline.
//   The instruction in D is compared against the producers in X and M.
//   The operand selects it will need in X are registered on the next
//   advancing edge. A load-use hazard against X stalls D for
//   LOAD_USE_STALL cycles.
//
// Parameters
//   LOAD_USE_STALL  stall cycles per load-use hazard (1..3)
//   ZERO_REG_GUARD  1: a producer writing x0 never matches a source
//   STAT_W          statistics counter width (only with FWD_STATS_EN)
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   inst_d/x/m   instructions in D, X and M
//   valid_x/m    X / M slot holds a real instruction (not a bubble)
//   advance      pipeline moves this cycle; 0 freezes all state
//   f_sel_A/B    rs1/rs2 select for X: 00 regfile, 01 W result, 10 M ALU
//   f_mem_sel    store data for M: 0 forward W result, 1 rs2 from pipeline
//   stall_d      hold F/D and inject a bubble into X
//   stall_cycles advancing edges spent stalled (FWD_STATS_EN only)
//   fwd_events   advancing edges that registered a forward (FWD_STATS_EN only)
//
// Optional feature macro: FWD_STATS_EN adds the two saturating counters.
module hazard_forward_unit #(
   parameter int LOAD_USE_STALL = 1,
   parameter int ZERO_REG_GUARD = 1
`ifdef FWD_STATS_EN
   ,
   parameter int STAT_W = 32
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] inst_d,
   input  logic [31:0] inst_x,
   input  logic [31:0] inst_m,
   input  logic        valid_x,
   input  logic        valid_m,
   input  logic        advance,
   output logic [1:0]  f_sel_A,
   output logic [1:0]  f_sel_B,
   output logic        f_mem_sel,
   output logic        stall_d
`ifdef FWD_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cycles,
   output logic [STAT_W-1:0] fwd_events
`endif
);

   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   // Counter reload: the detect cycle itself is the first stall cycle
   localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STALL = 1'b1} stall_state_t;

   function automatic logic op_writes_rd(input logic [4:0] op);
      logic w;
      case (op)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_OPIMM, OPC_OP, OPC_LOAD: w = 1'b1;
         default:                     w = 1'b0;
      endcase
      return w;
   endfunction

   function automatic logic op_reads_rs1(input logic [4:0] op);
      logic r;
      case (op)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: r = 1'b0;
         default:                                 r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic op_reads_rs2(input logic [4:0] op);
      logic r;
      case (op)
         OPC_OP, OPC_STORE, OPC_BRANCH: r = 1'b1;
         default:                       r = 1'b0;
      endcase
      return r;
   endfunction

   // Producer/consumer register match, with the optional x0 guard
   function automatic logic rd_match(input logic wr, input logic vld,
                                     input logic [4:0] rd, input logic [4:0] rs);
      return wr && vld && (rd == rs) &&
             ((ZERO_REG_GUARD == 32'sd0) || (rd != 5'd0));
   endfunction

   // Youngest producer wins; unread sources stay on the regfile
   function automatic logic [1:0] pick_sel(input logic used, input logic x_hit,
                                           input logic m_hit);
      logic [1:0] sel;
      if (!used) begin
         sel = 2'b00;
      end else if (x_hit) begin
         sel = 2'b10;
      end else if (m_hit) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   logic [1:0]   cnt_r;
   stall_state_t state_r;
   logic [1:0]   sel_a_r, sel_b_r;
   logic         mem_sel_r;

   logic         x_wr_s, m_wr_s, x_is_load_s, x_is_store_s;
   logic         d_rs1_s, d_rs2_s, d_rs2_stall_s;
   logic         x_hit1_s, x_hit2_s, m_hit1_s, m_hit2_s, m_hit_st_s;
   logic         detect_s, stall_s;
   logic [1:0]   cnt_nxt_s, nxt_a_s, nxt_b_s;
   logic         nxt_mem_s;
   logic         unused_s;

   // Decode, hazard detection and next-state selection
   always_comb begin
      x_wr_s       = op_writes_rd(inst_x[6:2]);
      m_wr_s       = op_writes_rd(inst_m[6:2]);
      x_is_load_s  = valid_x && (inst_x[6:2] == OPC_LOAD);
      x_is_store_s = valid_x && (inst_x[6:2] == OPC_STORE);
      d_rs1_s      = op_reads_rs1(inst_d[6:2]);
      d_rs2_s      = op_reads_rs2(inst_d[6:2]);
      // Store data never stalls: M-stage forwarding from W supplies it later
      d_rs2_stall_s = d_rs2_s && (inst_d[6:2] != OPC_STORE);

      x_hit1_s   = rd_match(x_wr_s, valid_x, inst_x[11:7], inst_d[19:15]);
      x_hit2_s   = rd_match(x_wr_s, valid_x, inst_x[11:7], inst_d[24:20]);
      m_hit1_s   = rd_match(m_wr_s, valid_m, inst_m[11:7], inst_d[19:15]);
      m_hit2_s   = rd_match(m_wr_s, valid_m, inst_m[11:7], inst_d[24:20]);
      m_hit_st_s = rd_match(m_wr_s, valid_m, inst_m[11:7], inst_x[24:20]);

      detect_s = x_is_load_s &&
                 ((d_rs1_s && x_hit1_s) || (d_rs2_stall_s && x_hit2_s));

      if (reset) begin
         stall_s = 1'b0;
      end else begin
         stall_s = detect_s || (state_r == ST_STALL);
      end

      if (detect_s) begin
         cnt_nxt_s = STALL_INIT;
      end else if (cnt_r != 2'd0) begin
         cnt_nxt_s = cnt_r - 2'd1;
      end else begin
         cnt_nxt_s = cnt_r;
      end

      // A load in X cannot forward its ALU result; only M may forward it
      if (stall_s) begin
         nxt_a_s = 2'b00;
         nxt_b_s = 2'b00;
      end else begin
         nxt_a_s = pick_sel(d_rs1_s, x_hit1_s && !x_is_load_s, m_hit1_s);
         nxt_b_s = pick_sel(d_rs2_s, x_hit2_s && !x_is_load_s, m_hit2_s);
      end

      nxt_mem_s = !(x_is_store_s && m_hit_st_s);
   end

   // Load-use stall counter and its IDLE/STALL state
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r   <= 2'd0;
         state_r <= ST_IDLE;
      end else if (advance) begin
         cnt_r   <= cnt_nxt_s;
         state_r <= (cnt_nxt_s != 2'd0) ? ST_STALL : ST_IDLE;
      end
   end

   // Registered forwarding selects, consumed by the instruction once in X
   always_ff @(posedge clock) begin
      if (reset) begin
         sel_a_r   <= 2'b00;
         sel_b_r   <= 2'b00;
         mem_sel_r <= 1'b1;
      end else if (advance) begin
         sel_a_r   <= nxt_a_s;
         sel_b_r   <= nxt_b_s;
         mem_sel_r <= nxt_mem_s;
      end
   end

`ifdef FWD_STATS_EN
   logic [STAT_W-1:0] stall_cnt_r, fwd_cnt_r;

   // Saturating statistics counters
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_r <= {STAT_W{1'b0}};
         fwd_cnt_r   <= {STAT_W{1'b0}};
      end else if (advance) begin
         if (stall_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
         if (((nxt_a_s != 2'b00) || (nxt_b_s != 2'b00) || !nxt_mem_s) &&
             (fwd_cnt_r != {STAT_W{1'b1}})) begin
            fwd_cnt_r <= fwd_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign stall_cycles = stall_cnt_r;
   assign fwd_events   = fwd_cnt_r;
`endif

   assign f_sel_A   = sel_a_r;
   assign f_sel_B   = sel_b_r;
   assign f_mem_sel = mem_sel_r;
   assign stall_d   = stall_s;

   // Instruction fields that play no part in hazard decisions
   assign unused_s = ^{inst_d[31:25], inst_d[14:7], inst_d[1:0],
                       inst_x[31:25], inst_x[19:12], inst_x[1:0],
                       inst_m[31:12], inst_m[1:0]};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//   Drives two instances (LOAD_USE_STALL = 1 and 3) with the same pipeline
//   contents. stall_d is combinational and is checked right after the inputs
//   settle. The registered selects are expected one edge later, so each step
//   queues its expected {A,B,mem} and pops it after the edge.
module tb_hazard_forward_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] inst_d, inst_x, inst_m;
   logic        valid_x, valid_m, advance;
   logic [1:0]  a1, b1, a3, b3;
   logic        mem1, mem3, st1, st3;
`ifdef FWD_STATS_EN
   logic [31:0] sc1, fe1, sc3, fe3;
`endif

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      string      tag;
      logic [4:0] e1;
      logic [4:0] e3;
   } exp_t;
   exp_t sb_q[$];

   always #5 clock = ~clock;

   hazard_forward_unit #(.LOAD_USE_STALL(1), .ZERO_REG_GUARD(1)) dut1 (
      .clock(clock), .reset(reset), .inst_d(inst_d), .inst_x(inst_x),
      .inst_m(inst_m), .valid_x(valid_x), .valid_m(valid_m), .advance(advance),
      .f_sel_A(a1), .f_sel_B(b1), .f_mem_sel(mem1), .stall_d(st1)
`ifdef FWD_STATS_EN
      , .stall_cycles(sc1), .fwd_events(fe1)
`endif
   );

   hazard_forward_unit #(.LOAD_USE_STALL(3), .ZERO_REG_GUARD(1)) dut3 (
      .clock(clock), .reset(reset), .inst_d(inst_d), .inst_x(inst_x),
      .inst_m(inst_m), .valid_x(valid_x), .valid_m(valid_m), .advance(advance),
      .f_sel_A(a3), .f_sel_B(b3), .f_mem_sel(mem3), .stall_d(st3)
`ifdef FWD_STATS_EN
      , .stall_cycles(sc3), .fwd_events(fe3)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   // One pipeline cycle: drive, check stall_d, queue expected selects, clock
   task automatic step(input string tag, input logic rst, input logic [31:0] d,
                       input logic [31:0] x, input logic [31:0] m,
                       input logic vx, input logic vm, input logic adv,
                       input logic es1, input logic es3,
                       input logic [4:0] e1, input logic [4:0] e3);
      exp_t ent;
      reset   = rst;
      inst_d  = d;
      inst_x  = x;
      inst_m  = m;
      valid_x = vx;
      valid_m = vm;
      advance = adv;
      #1;
      check_val({tag, ".stall1"}, {31'd0, st1}, {31'd0, es1});
      check_val({tag, ".stall3"}, {31'd0, st3}, {31'd0, es3});
      sb_q.push_back('{tag, e1, e3});
      @(posedge clock);
      #1;
      ent = sb_q.pop_front();
      check_val({ent.tag, ".sel1"}, {27'd0, a1, b1, mem1}, {27'd0, ent.e1});
      check_val({ent.tag, ".sel3"}, {27'd0, a3, b3, mem3}, {27'd0, ent.e3});
   endtask

   initial begin
      logic [31:0] nop, add5, sub6, addi7, add8, lw9, add10, add10b, sw11, add11;
      logic [31:0] addi5, lui6, sys5, beq56, sw9, add6b;
      nop    = 32'h0000_0013;
      add5   = enc_r(7'h00, 5'd2, 5'd1, 5'd5);
      sub6   = enc_r(7'h20, 5'd5, 5'd5, 5'd6);
      addi7  = enc_addi(12'd3, 5'd0, 5'd7);
      add8   = enc_r(7'h00, 5'd0, 5'd7, 5'd8);
      lw9    = enc_lw(12'd0, 5'd1, 5'd9);
      add10  = enc_r(7'h00, 5'd9, 5'd9, 5'd10);
      add10b = enc_r(7'h00, 5'd9, 5'd1, 5'd10);
      sw11   = enc_sw(12'd4, 5'd11, 5'd2);
      add11  = enc_r(7'h00, 5'd4, 5'd3, 5'd11);
      addi5  = enc_addi(12'd1, 5'd0, 5'd5);
      lui6   = {20'h00028, 5'd6, 7'b0110111};          // rs1 field holds 5
      sys5   = {12'd0, 5'd0, 3'b000, 5'd5, 7'b1110011}; // rd field holds 5
      beq56  = {7'd0, 5'd6, 5'd5, 3'b000, 5'd0, 7'b1100011};
      sw9    = enc_sw(12'd0, 5'd9, 5'd1);
      add6b  = enc_r(7'h00, 5'd2, 5'd1, 5'd6);

      //   tag            rst  D        X        M       vx   vm   adv  es1  es3  exp1       exp3
      step("rst0",       1'b1, add10,  lw9,    nop,   1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("hold_det",   1'b0, add10,  lw9,    nop,   1'b1,1'b1,1'b0,1'b1,1'b1,5'b00_00_1,5'b00_00_1);
      step("alu_b2b",    1'b0, sub6,   add5,   nop,   1'b1,1'b1,1'b1,1'b0,1'b0,5'b10_10_1,5'b10_10_1);
      step("dist2",      1'b0, add8,   nop,    addi7, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b01_00_1,5'b01_00_1);
      step("x0_guard",   1'b0, enc_r(7'h00, 5'd0, 5'd0, 5'd3), enc_addi(12'd1, 5'd1, 5'd0),
                         enc_r(7'h00, 5'd4, 5'd3, 5'd0),
                                                      1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("x_over_m",   1'b0, enc_r(7'h00, 5'd0, 5'd5, 5'd6), add5, addi5,
                                                      1'b1,1'b1,1'b1,1'b0,1'b0,5'b10_00_1,5'b10_00_1);
      step("bubble_x",   1'b0, sub6,   add5,   addi5, 1'b0,1'b1,1'b1,1'b0,1'b0,5'b01_01_1,5'b01_01_1);
      step("bubble_m",   1'b0, sub6,   nop,    addi5, 1'b1,1'b0,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("imm_no_rs2", 1'b0, enc_addi(12'd5, 5'd5, 5'd6), add5, nop,
                                                      1'b1,1'b1,1'b1,1'b0,1'b0,5'b10_00_1,5'b10_00_1);
      step("lui_no_rs1", 1'b0, lui6,   add5,   nop,   1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("sys_in_x",   1'b0, sub6,   sys5,   nop,   1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("branch",     1'b0, beq56,  add6b,  addi5, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b01_10_1,5'b01_10_1);
      step("freeze",     1'b0, sub6,   add5,   nop,   1'b1,1'b1,1'b0,1'b0,1'b0,5'b01_10_1,5'b01_10_1);
      step("st_fwd",     1'b0, nop,    sw11,   add11, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_0,5'b00_00_0);
      step("st_guard",   1'b0, nop,    enc_sw(12'd4, 5'd0, 5'd2), enc_r(7'h00, 5'd4, 5'd3, 5'd0),
                                                      1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("st_fwd2",    1'b0, nop,    sw11,   add11, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_0,5'b00_00_0);
      step("st_inval",   1'b0, nop,    sw11,   add11, 1'b0,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("st_fwd3",    1'b0, nop,    sw11,   add11, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_0,5'b00_00_0);
      step("rst_mem",    1'b1, nop,    sw11,   add11, 1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      step("st_no_stall",1'b0, sw9,    lw9,    nop,   1'b1,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      // Load-use: one stall cycle for dut1, three (plus one frozen) for dut3
      step("lu_t",       1'b0, add10,  lw9,    nop,   1'b1,1'b1,1'b1,1'b1,1'b1,5'b00_00_1,5'b00_00_1);
      step("lu_t1",      1'b0, add10,  nop,    lw9,   1'b0,1'b1,1'b1,1'b0,1'b1,5'b01_01_1,5'b00_00_1);
      step("lu_frz",     1'b0, add10,  nop,    lw9,   1'b0,1'b1,1'b0,1'b0,1'b1,5'b01_01_1,5'b00_00_1);
      step("lu_t2",      1'b0, add10,  nop,    nop,   1'b0,1'b0,1'b1,1'b0,1'b1,5'b00_00_1,5'b00_00_1);
      step("lu_t3",      1'b0, add10,  nop,    nop,   1'b0,1'b0,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
      // Load-use on rs2 only, then reset while dut3 still has two cycles left
      step("rs_t",       1'b0, add10b, lw9,    nop,   1'b1,1'b1,1'b1,1'b1,1'b1,5'b00_00_1,5'b00_00_1);
      step("rs_rst",     1'b1, add10b, nop,    lw9,   1'b0,1'b1,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);
`ifdef FWD_STATS_EN
      check_val("stats.sc1", sc1, 32'd0);
      check_val("stats.fe1", fe1, 32'd0);
      check_val("stats.sc3", sc3, 32'd0);
      check_val("stats.fe3", fe3, 32'd0);
`endif
      step("rs_after",   1'b0, add10b, nop,    nop,   1'b0,1'b0,1'b1,1'b0,1'b0,5'b00_00_1,5'b00_00_1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
